// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable divider: tick every (r_div+1) cycles, 50% divided clock, graceful stop.
// Optional 16-bit tick counter on o_tick_cnt when CLK_DIV_TICK_CNT_EN is defined.
module clk_div_ctrl #(
    parameter int CNT_BW = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [CNT_BW-1:0] i_div,
    input  logic              i_run,
    output logic              o_busy,
    output logic              o_clk_en,
    output logic              o_div_clk
`ifdef CLK_DIV_TICK_CNT_EN
    ,
    output logic [15:0]       o_tick_cnt
`endif
);

    // state | meaning
    // IDLE  | stopped, divided clock low, accepting configuration
    // RUN   | counting periods, ticking and toggling the divided clock
    // STOP  | stop requested, finishing until divided clock falls
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_BW-1:0] cnt;
    logic [CNT_BW-1:0] r_div;
    logic              div_clk_q;
    logic              tick;

    localparam logic [CNT_BW-1:0] CNT_ONE = {{(CNT_BW-1){1'b0}}, 1'b1};

    assign tick = (state != IDLE) && (cnt == r_div);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_run) state_nxt = RUN;
            RUN:     if (!i_run) state_nxt = STOP;
            // leave only on the falling tick so a high phase is never cut short
            STOP:    if (tick && div_clk_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (state != IDLE);
        o_cfg_ready = (state == IDLE);
        o_clk_en    = tick;
        o_div_clk   = div_clk_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div     <= '0;
            cnt       <= '0;
            div_clk_q <= 1'b0;
        end else begin
            if (i_cfg_valid && o_cfg_ready) begin
                r_div <= i_div;
            end
            // in STOP the exit tick always has div_clk_q high, so the toggle lands it low
            if (state == IDLE) begin
                cnt       <= '0;
                div_clk_q <= 1'b0;
            end else if (tick) begin
                cnt       <= '0;
                div_clk_q <= ~div_clk_q;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

`ifdef CLK_DIV_TICK_CNT_EN
    logic [15:0] tick_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else if ((state == IDLE) && (state_nxt == RUN)) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= tick_cnt_q + 16'd1;
        end
    end

    assign o_tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: reset, divisors 4/0/3/7/2, graceful stop, handshake edges, async reset.
module tb_clk_div_ctrl;

    logic       clk;
    logic       reset_n;
    logic       i_cfg_valid;
    logic       o_cfg_ready;
    logic [7:0] i_div;
    logic       i_run;
    logic       o_busy;
    logic       o_clk_en;
    logic       o_div_clk;
`ifdef CLK_DIV_TICK_CNT_EN
    logic [15:0] o_tick_cnt;
`endif

    int tests = 0;
    int fails = 0;

    clk_div_ctrl #(.CNT_BW(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_cfg_valid (i_cfg_valid),
        .o_cfg_ready (o_cfg_ready),
        .i_div       (i_div),
        .i_run       (i_run),
        .o_busy      (o_busy),
        .o_clk_en    (o_clk_en),
        .o_div_clk   (o_div_clk)
`ifdef CLK_DIV_TICK_CNT_EN
        ,
        .o_tick_cnt  (o_tick_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] div);
        i_cfg_valid = 1'b1;
        i_div       = div;
        tick();
        i_cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (o_busy && n < max_cycles) begin
            tick();
            n++;
        end
        check("idle_reached", int'(o_busy), 0);
        check("idle_div_clk_low", int'(o_div_clk), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        i_run       = 1'b1;
        i_cfg_valid = 1'b0;
        i_div       = 8'd0;

        // reset held with run requested
        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg_ready", int'(o_cfg_ready), 1);
        check("rst_busy", int'(o_busy), 0);
        check("rst_div_clk", int'(o_div_clk), 0);
        check("rst_clk_en", int'(o_clk_en), 0);
`ifdef CLK_DIV_TICK_CNT_EN
        check("rst_tick_cnt", int'(o_tick_cnt), 0);
`endif
        i_run   = 1'b0;
        reset_n = 1'b1;
        tick();
        check("idle_busy", int'(o_busy), 0);

        // divisor 4: period 5 ticks, 10-cycle divided clock
        cfg(8'd4);
        check("cfg4_still_idle", int'(o_busy), 0);
        i_run = 1'b1;
        tick();
        check("d4_busy", int'(o_busy), 1);
        check("d4_cfg_ready", int'(o_cfg_ready), 0);
        for (int k = 0; k < 50; k++) begin
            check($sformatf("d4_clk_en_k%0d", k), int'(o_clk_en), int'(k % 5 == 4));
            check($sformatf("d4_div_clk_k%0d", k), int'(o_div_clk), (k / 5) % 2);
            tick();
        end
        i_run = 1'b0;
        repeat (9) tick();
        check("d4_stop_high_busy", int'(o_busy), 1);
        check("d4_stop_high_div", int'(o_div_clk), 1);
        tick();
        check("d4_stop_busy", int'(o_busy), 0);
        check("d4_stop_div", int'(o_div_clk), 0);
        check("d4_stop_ready", int'(o_cfg_ready), 1);

        // divisor 0: enable every cycle, clk/2
        cfg(8'd0);
        i_run = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            check($sformatf("d0_clk_en_k%0d", k), int'(o_clk_en), 1);
            check($sformatf("d0_div_clk_k%0d", k), int'(o_div_clk), k % 2);
            tick();
        end
        i_run = 1'b0;
        tick();
        check("d0_stop_busy1", int'(o_busy), 1);
        check("d0_stop_div1", int'(o_div_clk), 1);
        tick();
        check("d0_stop_busy0", int'(o_busy), 0);
        check("d0_stop_div0", int'(o_div_clk), 0);

        // divisor 3, cfg offered during RUN must be ignored; stop mid high phase
        cfg(8'd3);
        i_run = 1'b1;
        tick();
        i_cfg_valid = 1'b1;
        i_div       = 8'd7;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("d3_clk_en_k%0d", k), int'(o_clk_en), int'(k == 3));
            check($sformatf("d3_div_clk_k%0d", k), int'(o_div_clk), int'(k >= 4));
            tick();
        end
        i_cfg_valid = 1'b0;
        check("d3_mid_high", int'(o_div_clk), 1);
        i_run = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            tick();
            check($sformatf("d3hi_busy_t%0d", t), int'(o_busy), int'(t < 3));
            check($sformatf("d3hi_div_t%0d", t), int'(o_div_clk), int'(t < 3));
        end

        // stop from low phase, run re-request during STOP ignored
        i_run = 1'b1;
        tick();
        for (int k = 0; k < 9; k++) begin
            check($sformatf("d3b_clk_en_k%0d", k), int'(o_clk_en), int'(k % 4 == 3));
            check($sformatf("d3b_div_clk_k%0d", k), int'(o_div_clk), (k / 4) % 2);
            tick();
        end
        i_run = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            if (t == 5) i_run = 1'b1;
            tick();
            check($sformatf("d3lo_busy_t%0d", t), int'(o_busy), int'(t < 7));
            check($sformatf("d3lo_div_t%0d", t), int'(o_div_clk), int'(t >= 3 && t <= 6));
        end
        check("d3lo_ready", int'(o_cfg_ready), 1);
        tick();
        check("restart_busy", int'(o_busy), 1);
        check("restart_ready", int'(o_cfg_ready), 0);
        i_run = 1'b0;
        wait_idle(40);

        // cfg and run on the same IDLE edge: period 8
        i_cfg_valid = 1'b1;
        i_div       = 8'd7;
        i_run       = 1'b1;
        tick();
        i_cfg_valid = 1'b0;
        check("d7_busy", int'(o_busy), 1);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("d7_clk_en_k%0d", k), int'(o_clk_en), int'(k % 8 == 7));
            check($sformatf("d7_div_clk_k%0d", k), int'(o_div_clk), (k / 8) % 2);
            tick();
        end
        check("d7_high_before_rst", int'(o_div_clk), 1);

        // asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_div_clk", int'(o_div_clk), 0);
        check("arst_busy", int'(o_busy), 0);
        check("arst_ready", int'(o_cfg_ready), 1);
        check("arst_clk_en", int'(o_clk_en), 0);
        i_run = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        check("post_rst_busy", int'(o_busy), 0);
        check("post_rst_ready", int'(o_cfg_ready), 1);
        cfg(8'd2);
        i_run = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            check($sformatf("d2_clk_en_k%0d", k), int'(o_clk_en), int'(k % 3 == 2));
            check($sformatf("d2_div_clk_k%0d", k), int'(o_div_clk), (k / 3) % 2);
            tick();
        end
        i_run = 1'b0;
        wait_idle(20);

`ifdef CLK_DIV_TICK_CNT_EN
        cfg(8'd0);
        i_run = 1'b1;
        tick();
        check("tc_cleared_on_start", int'(o_tick_cnt), 0);
        repeat (20) tick();
        check("tc_20", int'(o_tick_cnt), 20);
        i_run = 1'b0;
        wait_idle(10);
        check("tc_hold_idle", int'(o_tick_cnt), 22);
        i_run = 1'b1;
        tick();
        check("tc_restart", int'(o_tick_cnt), 0);
        i_run = 1'b0;
        wait_idle(10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
